wt_word_cache: RTL

- Direct-mapped, write-through, no-write-allocate word cache between the mp0 core's memory port and physical memory.
- CPU side uses the same handshake the core drives: mem_read/mem_write held until a one-cycle mem_resp.
- Memory side uses an identical request/response handshake prefixed pmem_.
- Read hits return without a physical access; every write goes to physical memory.

---
 rtl/wt_word_cache_pkg.sv | 22 ++
 rtl/wt_word_cache_array.sv | 58 +++++
 rtl/wt_word_cache.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wt_word_cache_pkg.sv
// Shared types and address-split helpers for the write-through word cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wt_word_cache_pkg;

    // Controller states: idle/lookup, read refill, write-through, response pulse
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WR_THRU = 2'd2,
        ST_RESP    = 2'd3
    } cache_state_e;

    localparam int ADDR_W        = 32;
    localparam int WORD_OFS_BITS = 2;

    // Tag width left over once the byte offset and the line index are removed
    function automatic int tag_bits(input int idx_bits);
        return ADDR_W - WORD_OFS_BITS - idx_bits;
    endfunction

endpackage

// File: rtl/wt_word_cache_array.sv
// Valid/tag/data storage for a direct-mapped cache of one-word lines.
// Latency: lookup is combinational; fill and write-hit update land on the next rising edge.
// Backpressure: none; the controller never fills and updates in the same cycle.
module wt_word_cache_array
    import wt_word_cache_pkg::*;
#(
    parameter int IDX_BITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IDX_BITS-1:0]           rd_idx,
    input  logic [tag_bits(IDX_BITS)-1:0] rd_tag,
    output logic                          hit,
    output logic [31:0]                   rd_data,
    input  logic                          fill_en,
    input  logic [IDX_BITS-1:0]           fill_idx,
    input  logic [tag_bits(IDX_BITS)-1:0] fill_tag,
    input  logic [31:0]                   fill_data,
    input  logic                          wr_en,
    input  logic [IDX_BITS-1:0]           wr_idx,
    input  logic [3:0]                    wr_be,
    input  logic [31:0]                   wr_data
);

    localparam int TAG_W = tag_bits(IDX_BITS);
    localparam int LINES = 1 << IDX_BITS;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

    // Valid bits are the only state reset clears; a fill marks its line valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag/data payload: whole-word refill, or byte-masked merge on a write hit
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/wt_word_cache.sv
// Direct-mapped write-through, no-write-allocate word cache with hit/miss counters.
// Latency: read hit 2 cycles; read miss and every write 2 cycles plus the pmem wait.
// Backpressure: requests are held by the CPU until mem_resp; pmem requests held until pmem_resp.
module wt_word_cache
    import wt_word_cache_pkg::*;
#(
    parameter int IDX_BITS = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [3:0]       mem_byte_enable,
    input  logic [31:0]      mem_address,
    input  logic [31:0]      mem_wdata,
    output logic [31:0]      mem_rdata,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [31:0]      pmem_address,
    output logic [31:0]      pmem_wdata,
    output logic [3:0]       pmem_byte_enable,
    input  logic [31:0]      pmem_rdata,
    input  logic             pmem_resp,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int              TAG_W   = tag_bits(IDX_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    cache_state_e state_q, state_d;

    logic [31:2]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [31:0]      rdata_q;

    logic             hit;
    logic [31:0]      line_data;
    logic             fill_en;
    logic             wr_hit_en;
    logic             unused_addr_bits;

    // The word offset never reaches the array or physical memory
    assign unused_addr_bits = ^mem_address[1:0];

    wt_word_cache_array #(
        .IDX_BITS (IDX_BITS)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (mem_address[IDX_BITS+1:2]),
        .rd_tag    (mem_address[31:IDX_BITS+2]),
        .hit       (hit),
        .rd_data   (line_data),
        .fill_en   (fill_en),
        .fill_idx  (addr_q[IDX_BITS+1:2]),
        .fill_tag  (addr_q[31:IDX_BITS+2]),
        .fill_data (pmem_rdata),
        .wr_en     (wr_hit_en),
        .wr_idx    (mem_address[IDX_BITS+1:2]),
        .wr_be     (mem_byte_enable),
        .wr_data   (mem_wdata)
    );

    assign pmem_address = {addr_q, 2'b00};
    assign pmem_wdata   = wdata_q;
    assign mem_rdata    = rdata_q;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; a write outranks a simultaneous read
    always_comb begin
        state_d          = state_q;
        mem_resp         = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_byte_enable = 4'hF;
        fill_en          = 1'b0;
        wr_hit_en        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_write) begin
                    wr_hit_en = hit;
                    state_d   = ST_WR_THRU;
                end else if (mem_read) begin
                    state_d = hit ? ST_RESP : ST_RD_MISS;
                end
            end
            ST_RD_MISS: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill_en = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_WR_THRU: begin
                pmem_write       = 1'b1;
                pmem_byte_enable = be_q;
                if (pmem_resp) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                mem_resp = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latches, returned read data and saturating read hit/miss counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mem_write) begin
                        addr_q  <= mem_address[31:2];
                        wdata_q <= mem_wdata;
                        be_q    <= mem_byte_enable;
                    end else if (mem_read && hit) begin
                        rdata_q <= line_data;
                        if (hit_count != '1) begin
                            hit_count <= hit_count + CNT_ONE;
                        end
                    end else if (mem_read) begin
                        addr_q <= mem_address[31:2];
                        if (miss_count != '1) begin
                            miss_count <= miss_count + CNT_ONE;
                        end
                    end
                end
                ST_RD_MISS: begin
                    if (pmem_resp) begin
                        rdata_q <= pmem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
